// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SHOW
  } state_t;

  localparam logic [31:0] DEFAULT_PC_STEP = 32'd4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter with a zero flag; one instance is shared by the
// WAIT and SHOW phases of the fetch sequencer.
module seq_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         RST,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch: FETCH -> WAIT (RAM latency) -> SHOW (dwell),
// then advance or redirect the PC. Free-run via run, single-step via step.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned DWELL    = 4,
  parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        run,
  input  logic        step,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        mem_ce,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic        busy
);

  localparam int unsigned TW = $clog2(max_u(MEM_LAT, DWELL) + 1);
  localparam logic [TW-1:0] WAIT_LOAD = TW'(MEM_LAT - 1);
  localparam logic [TW-1:0] SHOW_LOAD = TW'(DWELL - 1);

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0] tmr_val;

  seq_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .RST        (RST),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    case (state_q)
      S_IDLE: begin
        if (run || step) state_d = S_FETCH;
      end
      S_FETCH: begin
        tmr_load = 1'b1;
        tmr_val  = WAIT_LOAD;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (tmr_zero) begin
          instr_d  = mem_rdata;
          tmr_load = 1'b1;
          tmr_val  = SHOW_LOAD;
          state_d  = S_SHOW;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_SHOW: begin
        // redirect only matters on the final dwell cycle
        if (tmr_zero) begin
          pc_d    = redirect ? redirect_addr : (pc_q + PC_STEP);
          state_d = run ? S_FETCH : S_IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_ce      = (state_q == S_FETCH) || (state_q == S_WAIT);
    instr_valid = (state_q == S_SHOW);
    busy        = (state_q != S_IDLE);
  end

  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign instr    = instr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: default instance plus a wrap/latency-2 instance.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic RST;

  // default-parameter instance
  logic        run_a, step_a, redir_a;
  logic [31:0] raddr_a, rdata_a, addr_a, instr_a, pc_a;
  logic        ce_a, valid_a, busy_a;
  logic [31:0] ram_a [0:31];

  // wrap-around / MEM_LAT=2 instance
  logic        step_b;
  logic [31:0] rdata_b, addr_b, instr_b, pc_b;
  logic        ce_b, valid_b, busy_b;

  fetch_sequencer dut_a (
    .clk(clk), .RST(RST), .run(run_a), .step(step_a), .redirect(redir_a),
    .redirect_addr(raddr_a), .mem_ce(ce_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .instr(instr_a), .instr_valid(valid_a), .pc(pc_a), .busy(busy_a)
  );

  fetch_sequencer #(.MEM_LAT(2), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .RST(RST), .run(1'b0), .step(step_b), .redirect(1'b0),
    .redirect_addr(32'h0), .mem_ce(ce_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .instr(instr_b), .instr_valid(valid_b), .pc(pc_b), .busy(busy_b)
  );

  initial begin
    for (int i = 0; i < 32; i++) ram_a[i] = 32'hA000_0000 + i;
    ram_a[0] = 32'h2002_0005;
  end

  always @(posedge clk) if (ce_a) rdata_a <= ram_a[addr_a[6:2]];
  always @(posedge clk) if (ce_b) rdata_b <= 32'hCAFE_0000 | {16'h0, addr_b[15:0]};

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_addr;
    int ph;
    int ce_cnt;
    RST = 1'b0; run_a = 0; step_a = 0; redir_a = 0; raddr_a = 0; step_b = 0;
    rdata_a = 0; rdata_b = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'h0, busy_a}, 32'h0);
    check_eq("rst_ce", {31'h0, ce_a}, 32'h0);
    check_eq("rst_valid", {31'h0, valid_a}, 32'h0);
    check_eq("rst_pc", pc_a, 32'h0);
    check_eq("rst_instr", instr_a, 32'h0);
    check_eq("rst_pc_b", pc_b, 32'hFFFF_FFFC);
    RST = 1'b1;

    // single step; step during SHOW must be ignored
    step_a = 1;
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      step_a = (c == 4);
      $display("step c=%0d ce=%0b addr=%h valid=%0b instr=%h pc=%h busy=%0b",
               c, ce_a, addr_a, valid_a, instr_a, pc_a, busy_a);
      check_eq($sformatf("step_ce_c%0d", c), {31'h0, ce_a}, {31'h0, (c == 1 || c == 2)});
      check_eq($sformatf("step_valid_c%0d", c), {31'h0, valid_a}, {31'h0, (c >= 3 && c <= 6)});
      check_eq($sformatf("step_busy_c%0d", c), {31'h0, busy_a}, {31'h0, (c <= 6)});
      if (c == 1) check_eq("step_addr", addr_a, 32'h0);
      if (c >= 3) check_eq($sformatf("step_instr_c%0d", c), instr_a, 32'h2002_0005);
      check_eq($sformatf("step_pc_c%0d", c), pc_a, (c >= 7) ? 32'h4 : 32'h0);
    end

    // reset back to pc 0, then free-run with redirects and a run drop
    RST = 1'b0;
    #1;
    check_eq("rst2_pc", pc_a, 32'h0);
    next_cycle();
    RST = 1'b1;
    run_a = 1;
    for (int c = 1; c <= 27; c++) begin
      next_cycle();
      redir_a = 0;
      if (c <= 18) begin
        ph = (c - 1) % 6;
        exp_addr = 32'(4 * ((c - 1) / 6));
      end else if (c <= 24) begin
        ph = c - 19;
        exp_addr = 32'h40;
      end else begin
        ph = -1;
        exp_addr = 32'h44;
      end
      $display("run c=%0d ce=%0b addr=%h valid=%0b instr=%h pc=%h busy=%0b",
               c, ce_a, addr_a, valid_a, instr_a, pc_a, busy_a);
      check_eq($sformatf("run_busy_c%0d", c), {31'h0, busy_a}, {31'h0, (ph >= 0)});
      check_eq($sformatf("run_ce_c%0d", c), {31'h0, ce_a}, {31'h0, (ph == 0 || ph == 1)});
      check_eq($sformatf("run_valid_c%0d", c), {31'h0, valid_a}, {31'h0, (ph >= 2)});
      check_eq($sformatf("run_pc_c%0d", c), pc_a, exp_addr);
      if (ph == 0) check_eq($sformatf("run_addr_c%0d", c), addr_a, exp_addr);
      if (ph >= 2) check_eq($sformatf("run_instr_c%0d", c), instr_a, ram_a[exp_addr[6:2]]);
      if (c == 10) begin redir_a = 1; raddr_a = 32'h80; end
      if (c == 18) begin redir_a = 1; raddr_a = 32'h40; end
      if (c == 20) run_a = 0;
    end

    // asynchronous reset during WAIT discards the fetch
    step_a = 1;
    next_cycle();
    step_a = 0;
    next_cycle();
    check_eq("pre_rst_ce", {31'h0, ce_a}, 32'h1);
    #2;
    RST = 1'b0;
    #1;
    $display("async reset ce=%0b pc=%h instr=%h busy=%0b", ce_a, pc_a, instr_a, busy_a);
    check_eq("arst_ce", {31'h0, ce_a}, 32'h0);
    check_eq("arst_pc", pc_a, 32'h0);
    check_eq("arst_instr", instr_a, 32'h0);
    check_eq("arst_busy", {31'h0, busy_a}, 32'h0);
    #3;
    RST = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      check_eq($sformatf("post_rst_busy_c%0d", c), {31'h0, busy_a}, 32'h0);
      check_eq($sformatf("post_rst_instr_c%0d", c), instr_a, 32'h0);
    end

    // wrap-around with MEM_LAT=2
    ce_cnt = 0;
    step_b = 1;
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      step_b = 0;
      $display("wrap c=%0d ce=%0b addr=%h valid=%0b instr=%h pc=%h busy=%0b",
               c, ce_b, addr_b, valid_b, instr_b, pc_b, busy_b);
      if (ce_b) ce_cnt++;
      check_eq($sformatf("wrap_ce_c%0d", c), {31'h0, ce_b}, {31'h0, (c >= 1 && c <= 3)});
      check_eq($sformatf("wrap_valid_c%0d", c), {31'h0, valid_b}, {31'h0, (c >= 4 && c <= 7)});
      if (c == 1) check_eq("wrap_addr", addr_b, 32'hFFFF_FFFC);
      if (c >= 4) check_eq($sformatf("wrap_instr_c%0d", c), instr_b, 32'hCAFE_FFFC);
      check_eq($sformatf("wrap_pc_c%0d", c), pc_b, (c >= 8) ? 32'h0 : 32'hFFFF_FFFC);
    end
    check_eq("wrap_ce_count", 32'(ce_cnt), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle instruction-fetch sequencer that owns the PC and drives the instruction block RAM, replacing the free-running pc/clk_div pairing. It issues one fetch at a time and waits a fixed read latency. It then holds the captured instruction stable for a dwell period so the controller decode and the seven-segment display can consume it, and finally advances or redirects the PC. It supports free-run and single-step modes.

## Interface
- `MEM_LAT`, 1: instruction RAM read latency in cycles (≥1).
- `DWELL`, 4: cycles the instruction is held in SHOW (≥1).
- `PC_STEP`, 4: byte increment per instruction.
- `RESET_PC`, 32'h0: PC value after reset.
- `clk` in 1: single clock; all state on rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `run` in 1: level; while high, fetches back-to-back.
- `step` in 1: one-cycle pulse; fetches exactly one instruction when idle.
- `redirect` in 1: taken jump/branch for the instruction currently shown.
- `redirect_addr` in 32: target PC, used when `redirect` is sampled.
- `mem_ce` out 1: RAM enable.
- `mem_addr` out 32: RAM address, equal to registered `pc`.
- `mem_rdata` in 32: RAM read data.
- `instr` out 32: captured instruction, held until the next capture.
- `instr_valid` out 1: high exactly during SHOW.
- `pc` out 32: address of the current/last fetched instruction.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States are IDLE, FETCH, WAIT and SHOW.
- IDLE:
  - `mem_ce`=0.
  - Goes to FETCH if `run`=1 or `step`=1. Both high is treated as run.
- FETCH, one cycle:
  - `mem_ce`=1, `mem_addr`=`pc`.
  - Loads the timer with MEM_LAT-1, then goes to WAIT.
- WAIT, MEM_LAT cycles:
  - `mem_ce` held at 1, so the RAM output register updates.
  - On the last WAIT cycle, `mem_rdata` is registered into `instr`.
  - Loads the timer with DWELL-1, then goes to SHOW.
- SHOW, DWELL cycles:
  - `instr_valid`=1.
  - On the last SHOW cycle, `pc` <= `redirect` ? `redirect_addr` : `pc`+PC_STEP.
  - Next state is FETCH if `run`=1 at that cycle, else IDLE.
- `step` is ignored outside IDLE. It is not queued.
- Dropping `run` mid-instruction finishes the current instruction, then goes to IDLE.
- `redirect` is sampled only on the last SHOW cycle and ignored elsewhere.
- `redirect_addr` is used unmodified. No alignment is forced.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- Reset while in any state returns immediately to reset values. A partially fetched instruction is discarded.
- Reset values:
  - state = IDLE
  - `pc` = `mem_addr` = RESET_PC
  - `instr` = 0
  - `instr_valid` = `mem_ce` = `busy` = 0
  - timer = 0

## Timing
- Trigger sampled at edge k puts the block in FETCH during cycle k+1.
- WAIT occupies cycles k+2 .. k+1+MEM_LAT.
- SHOW occupies the next DWELL cycles.
- Instruction period in run mode is 1+MEM_LAT+DWELL cycles. With defaults this is 6.
- `instr` changes only at the edge entering SHOW. It is stable through SHOW and through IDLE afterwards.
- `pc` changes only at the edge leaving SHOW.
- All outputs are registered or decoded from registered state. There is no combinational input-to-output path.

## Structure
- Package `fetch_seq_pkg`: state enum (IDLE, FETCH, WAIT, SHOW) and the default PC_STEP constant.
- Sub-module `seq_timer`: loadable down-counter, width $clog2(max(MEM_LAT,DWELL)+1), with a `zero` flag. It is shared by WAIT and SHOW.
- The top-level FSM and the PC/instr registers stay in `fetch_sequencer`.

## Test plan
- Defaults, RAM word0=32'h2002_0005:
  - Stimulus: `step` pulse at cycle 0.
  - Response: FETCH at cycle 1 with `mem_addr`=0. `instr`=32'h2002_0005 with `instr_valid` during cycles 3–6. `pc`=4 and IDLE at cycle 7.
- `run` held high for 3 instructions:
  - `mem_addr` sequence is 0, 4, 8.
  - FETCH occurs at cycles 1, 7, 13.
  - `busy` stays 1 throughout.
- Redirect at end of dwell:
  - Stimulus: `redirect`=1 with `redirect_addr`=32'h40 on the last SHOW cycle of the instruction at pc 8.
  - Response: next FETCH presents `mem_addr`=32'h40.
  - Also: `redirect` pulsed mid-SHOW has no effect.
- Mode changes and ignored step:
  - `run` dropped during WAIT: SHOW completes, `pc` advances, block enters IDLE.
  - `step` during SHOW is ignored: no second fetch.
- Reset mid-operation:
  - Stimulus: `RST` low during WAIT.
  - Response: asynchronously `mem_ce`=0, `pc`=0, `instr`=0, IDLE. No capture after release.
- Wrap-around:
  - Stimulus: `RESET_PC`=32'hFFFF_FFFC, one `step`.
  - Response: `pc`=0 after SHOW.
  - Also: `MEM_LAT`=2 gives `mem_ce` high for 3 cycles per fetch.
